// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the multicycle Hack CPU core:
//   - control FSM state encoding
//   - instruction-register field positions
//   - reset constants
//   - jump-condition helper
// No ports (package).
// -----------------------------------------------------------------------------
package hack_pkg;

   // Control FSM states; explicit codes keep the encoding stable for debug taps.
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      MEM_RD = 3'd2,
      EXEC   = 3'd3,
      MEM_WR = 3'd4
   } state_t;

   // Instruction-register field bit positions.
   localparam int unsigned IS_C    = 15;
   localparam int unsigned A_SEL   = 12;
   localparam int unsigned COMP_HI = 11;
   localparam int unsigned COMP_LO = 6;
   localparam int unsigned DEST_A  = 5;
   localparam int unsigned DEST_D  = 4;
   localparam int unsigned DEST_M  = 3;
   localparam int unsigned JMP_HI  = 2;
   localparam int unsigned JMP_LO  = 0;

   // Reset constants.
   localparam logic [15:0] WORD_RESET = 16'h0000;
   localparam logic [14:0] ADDR_RESET = 15'h0000;

   // Jump bits are (lt, eq, gt); gt means strictly positive (not ng and not zr).
   function automatic logic jump_taken(input logic [2:0] jmp,
                                       input logic       zr,
                                       input logic       ng);
      return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
   endfunction

endpackage : hack_pkg

// File: rtl/hack_cpu_core_alu.sv
// -----------------------------------------------------------------------------
// hack_cpu_core_alu
// Combinational Hack ALU (16-bit, modulo arithmetic).
// Ports:
//   x_i, y_i          operands
//   zx_i, nx_i        zero / negate x
//   zy_i, ny_i        zero / negate y
//   f_i               1: x+y, 0: x&y
//   no_i              negate output
//   out_o             result
//   zr_o              result is zero
//   ng_o              result is negative (bit 15)
// -----------------------------------------------------------------------------
module hack_cpu_core_alu (
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic        zx_i,
   input  logic        nx_i,
   input  logic        zy_i,
   input  logic        ny_i,
   input  logic        f_i,
   input  logic        no_i,
   output logic [15:0] out_o,
   output logic        zr_o,
   output logic        ng_o
);

   logic [15:0] x_z_s;
   logic [15:0] x_n_s;
   logic [15:0] y_z_s;
   logic [15:0] y_n_s;
   logic [15:0] f_s;

   assign x_z_s = zx_i ? 16'h0000 : x_i;
   assign x_n_s = nx_i ? ~x_z_s : x_z_s;
   assign y_z_s = zy_i ? 16'h0000 : y_i;
   assign y_n_s = ny_i ? ~y_z_s : y_z_s;
   assign f_s   = f_i ? (x_n_s + y_n_s) : (x_n_s & y_n_s);
   assign out_o = no_i ? ~f_s : f_s;
   assign zr_o  = (out_o == 16'h0000);
   assign ng_o  = out_o[15];

endmodule : hack_cpu_core_alu

// File: rtl/hack_cpu_core.sv
// -----------------------------------------------------------------------------
// hack_cpu_core
// Multicycle Hack CPU: fetch over a request/valid instruction port, decode
// A/C instructions, drive the ALU, write back to A/D/data memory over a
// request/ready data port, and resolve jumps.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   imem_req/addr           fetch request (held until imem_valid), address = pc
//   imem_valid/data         fetched instruction
//   dmem_rd/wr              data read / write request (held until dmem_ready)
//   dmem_addr/wdata         data address / write data
//   dmem_rdata/ready        read data / transaction completion
//   pc, a_reg, d_reg        architectural state
//   retire                  one-cycle pulse when an instruction completes
// -----------------------------------------------------------------------------
module hack_cpu_core
   import hack_pkg::*;
#(
   parameter logic [14:0] PC_RESET = 15'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [14:0] imem_addr,
   input  logic        imem_valid,
   input  logic [15:0] imem_data,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [14:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [14:0] pc,
   output logic [15:0] a_reg,
   output logic [15:0] d_reg,
   output logic        retire
);

   state_t      state_q, state_d;
   logic [14:0] pc_q, pc_d;
   logic [15:0] a_q, a_d;
   logic [15:0] d_q, d_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] m_q, m_d;
   logic [14:0] daddr_q, daddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        retire_s;

   logic [15:0] alu_y_s;
   logic [15:0] alu_out_s;
   logic        alu_zr_s;
   logic        alu_ng_s;
   logic [5:0]  comp_s;
   logic [14:0] pc_inc_s;

   assign comp_s   = ir_q[COMP_HI:COMP_LO];
   assign alu_y_s  = ir_q[A_SEL] ? m_q : a_q;
   assign pc_inc_s = pc_q + 15'd1;   // wraps 7FFF -> 0000 naturally

   hack_cpu_core_alu u_alu (
      .x_i   (d_q),
      .y_i   (alu_y_s),
      .zx_i  (comp_s[5]),
      .nx_i  (comp_s[4]),
      .zy_i  (comp_s[3]),
      .ny_i  (comp_s[2]),
      .f_i   (comp_s[1]),
      .no_i  (comp_s[0]),
      .out_o (alu_out_s),
      .zr_o  (alu_zr_s),
      .ng_o  (alu_ng_s)
   );

   // Next-state and datapath update logic for the multicycle FSM.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      a_d      = a_q;
      d_d      = d_q;
      ir_d     = ir_q;
      m_d      = m_q;
      daddr_d  = daddr_q;
      wdata_d  = wdata_q;
      retire_s = 1'b0;

      case (state_q)
         FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_data;
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end

         DECODE: begin
            if (!ir_q[IS_C]) begin
               a_d      = {1'b0, ir_q[14:0]};
               pc_d     = pc_inc_s;
               retire_s = 1'b1;
               state_d  = FETCH;
            end else if (ir_q[A_SEL]) begin
               // Read address is captured here so it is stable for the whole read.
               daddr_d = a_q[14:0];
               state_d = MEM_RD;
            end else begin
               state_d = EXEC;
            end
         end

         MEM_RD: begin
            if (dmem_ready) begin
               m_d     = dmem_rdata;
               state_d = EXEC;
            end else begin
               state_d = MEM_RD;
            end
         end

         EXEC: begin
            // Jump target and store address use the pre-instruction A value.
            if (jump_taken(ir_q[JMP_HI:JMP_LO], alu_zr_s, alu_ng_s)) begin
               pc_d = a_q[14:0];
            end else begin
               pc_d = pc_inc_s;
            end
            if (ir_q[DEST_A]) begin
               a_d = alu_out_s;
            end else begin
               a_d = a_q;
            end
            if (ir_q[DEST_D]) begin
               d_d = alu_out_s;
            end else begin
               d_d = d_q;
            end
            if (ir_q[DEST_M]) begin
               daddr_d = a_q[14:0];
               wdata_d = alu_out_s;
               state_d = MEM_WR;
            end else begin
               retire_s = 1'b1;
               state_d  = FETCH;
            end
         end

         MEM_WR: begin
            if (dmem_ready) begin
               retire_s = 1'b1;
               state_d  = FETCH;
            end else begin
               state_d = MEM_WR;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // State and architectural registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= PC_RESET;
         a_q     <= WORD_RESET;
         d_q     <= WORD_RESET;
         ir_q    <= WORD_RESET;
         m_q     <= WORD_RESET;
         daddr_q <= ADDR_RESET;
         wdata_q <= WORD_RESET;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         d_q     <= d_d;
         ir_q    <= ir_d;
         m_q     <= m_d;
         daddr_q <= daddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Requests are gated with reset so an abandoned transaction drops at once.
   assign imem_req   = (state_q == FETCH)  & ~reset;
   assign dmem_rd    = (state_q == MEM_RD) & ~reset;
   assign dmem_wr    = (state_q == MEM_WR) & ~reset;
   assign retire     = retire_s & ~reset;
   assign imem_addr  = pc_q;
   assign dmem_addr  = daddr_q;
   assign dmem_wdata = wdata_q;
   assign pc         = pc_q;
   assign a_reg      = a_q;
   assign d_reg      = d_q;

endmodule : hack_cpu_core

// File: tb/tb_hack_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_hack_cpu_core
// Directed self-checking bench for hack_cpu_core. Each task runs one scenario
// and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hack_cpu_core;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [14:0] imem_addr;
   logic        imem_valid;
   logic [15:0] imem_data;
   logic        dmem_rd;
   logic        dmem_wr;
   logic [14:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ready;
   logic [14:0] pc;
   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic        retire;

   int total;
   int bad;

   // Observations from the last run_instr call.
   int          lat;
   int          rd_cycles;
   int          wr_cycles;
   int          both_high;
   int          unstable;
   logic [14:0] fetch_addr;
   logic [14:0] rd_addr;
   logic [14:0] wr_addr;
   logic [15:0] wr_data;

   hack_cpu_core #(.PC_RESET(15'h0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_data  (imem_data),
      .dmem_rd    (dmem_rd),
      .dmem_wr    (dmem_wr),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ready (dmem_ready),
      .pc         (pc),
      .a_reg      (a_reg),
      .d_reg      (d_reg),
      .retire     (retire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one instruction from a FETCH-state negedge until retire (40-cycle bound).
   // lat counts the first FETCH cycle as 1; lat stays -1 on timeout.
   task automatic run_instr(input logic [15:0] instr, input int rd_wait,
                            input logic [15:0] rdata, input int wr_wait);
      bit done;
      bit fetched;
      done = 1'b0; fetched = 1'b0; lat = -1;
      rd_cycles = 0; wr_cycles = 0; both_high = 0; unstable = 0;
      fetch_addr = 15'h0000; rd_addr = 15'h0000; wr_addr = 15'h0000; wr_data = 16'h0000;
      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         imem_valid = 1'b0; dmem_ready = 1'b0; dmem_rdata = 16'h0000;
         #1;
         if (imem_req && !fetched) begin
            fetched = 1'b1; fetch_addr = imem_addr;
            imem_valid = 1'b1; imem_data = instr;
         end
         if (dmem_rd && dmem_wr) both_high++;
         if (dmem_rd) begin
            if (rd_cycles == 0) rd_addr = dmem_addr;
            else if (dmem_addr !== rd_addr) unstable++;
            if (rd_cycles == rd_wait) begin dmem_ready = 1'b1; dmem_rdata = rdata; end
            rd_cycles++;
         end
         if (dmem_wr) begin
            if (wr_cycles == 0) begin wr_addr = dmem_addr; wr_data = dmem_wdata; end
            else if (dmem_addr !== wr_addr || dmem_wdata !== wr_data) unstable++;
            if (wr_cycles == wr_wait) dmem_ready = 1'b1;
            wr_cycles++;
         end
         #1;
         if (retire === 1'b1) begin done = 1'b1; lat = cyc; end
         @(negedge clk);
      end
      imem_valid = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_valid = 1'b0; imem_data = 16'h0000;
      dmem_ready = 1'b0; dmem_rdata = 16'h0000;
      repeat (2) @(negedge clk);
      total++; if (pc !== 15'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", pc); end
      total++; if (a_reg !== 16'h0000 || d_reg !== 16'h0000) begin bad++; $display("FAIL rst_ad got a=%h d=%h exp 0/0", a_reg, d_reg); end
      total++; if ({imem_req, dmem_rd, dmem_wr, retire} !== 4'b0000) begin bad++; $display("FAIL rst_req got=%b exp=0000", {imem_req, dmem_rd, dmem_wr, retire}); end
      total++; if (dmem_addr !== 15'h0000 || dmem_wdata !== 16'h0000) begin bad++; $display("FAIL rst_dmem got addr=%h data=%h exp 0/0", dmem_addr, dmem_wdata); end
      reset = 1'b0;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin bad++; $display("FAIL rst_fetch got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
      @(negedge clk);
   endtask

   task automatic test_a_instr();
      run_instr(16'h0005, 0, 16'h0000, 0);
      total++; if (lat !== 2) begin bad++; $display("FAIL a_lat got=%0d exp=2", lat); end
      total++; if (a_reg !== 16'h0005) begin bad++; $display("FAIL a_val got=%h exp=0005", a_reg); end
      total++; if (pc !== 15'h0001) begin bad++; $display("FAIL a_pc got=%h exp=0001", pc); end
   endtask

   task automatic test_c_alu();
      run_instr(16'hEC10, 0, 16'h0000, 0);   // D=A
      total++; if (lat !== 3) begin bad++; $display("FAIL c_lat got=%0d exp=3", lat); end
      total++; if (d_reg !== 16'h0005) begin bad++; $display("FAIL c_d got=%h exp=0005", d_reg); end
      total++; if (pc !== 15'h0002) begin bad++; $display("FAIL c_pc got=%h exp=0002", pc); end
      total++; if (rd_cycles !== 0 || wr_cycles !== 0) begin bad++; $display("FAIL c_nomem got rd=%0d wr=%0d exp 0/0", rd_cycles, wr_cycles); end
   endtask

   task automatic test_mem_write();
      run_instr(16'hE308, 0, 16'h0000, 3);   // M=D, ready withheld 3 cycles
      total++; if (wr_cycles !== 4) begin bad++; $display("FAIL wr_hold got=%0d exp=4", wr_cycles); end
      total++; if (wr_addr !== 15'h0005 || wr_data !== 16'h0005) begin bad++; $display("FAIL wr_bus got addr=%h data=%h exp 0005/0005", wr_addr, wr_data); end
      total++; if (unstable !== 0) begin bad++; $display("FAIL wr_stable got=%0d exp=0", unstable); end
      total++; if (lat !== 7) begin bad++; $display("FAIL wr_lat got=%0d exp=7", lat); end
      total++; if (pc !== 15'h0003) begin bad++; $display("FAIL wr_pc got=%h exp=0003", pc); end
   endtask

   task automatic test_mem_rmw();
      run_instr(16'h0007, 0, 16'h0000, 0);
      run_instr(16'hFDE8, 0, 16'h0003, 0);   // AM=M+1
      total++; if (rd_cycles !== 1 || rd_addr !== 15'h0007) begin bad++; $display("FAIL rmw_rd got n=%0d addr=%h exp 1/0007", rd_cycles, rd_addr); end
      total++; if (wr_cycles !== 1 || wr_addr !== 15'h0007 || wr_data !== 16'h0004) begin bad++; $display("FAIL rmw_wr got n=%0d addr=%h data=%h exp 1/0007/0004", wr_cycles, wr_addr, wr_data); end
      total++; if (a_reg !== 16'h0004) begin bad++; $display("FAIL rmw_a got=%h exp=0004", a_reg); end
      total++; if (lat !== 5) begin bad++; $display("FAIL rmw_lat got=%0d exp=5", lat); end
      total++; if (both_high !== 0) begin bad++; $display("FAIL rmw_excl got=%0d exp=0", both_high); end
      total++; if (pc !== 15'h0005) begin bad++; $display("FAIL rmw_pc got=%h exp=0005", pc); end
   endtask

   task automatic test_jump();
      run_instr(16'hEA90, 0, 16'h0000, 0);   // D=0, pc 6
      run_instr(16'h000A, 0, 16'h0000, 0);   // A=10, pc 7
      run_instr(16'hE302, 0, 16'h0000, 0);   // D;JEQ taken
      total++; if (pc !== 15'h000A) begin bad++; $display("FAIL jeq_taken got=%h exp=000a", pc); end
      run_instr(16'hEFD0, 0, 16'h0000, 0);   // D=1, pc 11
      run_instr(16'hE302, 0, 16'h0000, 0);   // D;JEQ not taken
      total++; if (pc !== 15'h000C) begin bad++; $display("FAIL jeq_not got=%h exp=000c", pc); end
      run_instr(16'hE307, 0, 16'h0000, 0);   // D;JMP
      total++; if (pc !== 15'h000A) begin bad++; $display("FAIL jmp got=%h exp=000a", pc); end
      run_instr(16'hEDE7, 0, 16'h0000, 0);   // A=A+1;JMP -> target is old A
      total++; if (pc !== 15'h000A || a_reg !== 16'h000B) begin bad++; $display("FAIL jmp_olda got pc=%h a=%h exp 000a/000b", pc, a_reg); end
   endtask

   task automatic test_pc_wrap();
      run_instr(16'h7FFF, 0, 16'h0000, 0);
      run_instr(16'hEA87, 0, 16'h0000, 0);   // 0;JMP to 7FFF
      total++; if (pc !== 15'h7FFF) begin bad++; $display("FAIL wrap_pre got=%h exp=7fff", pc); end
      run_instr(16'h1234, 0, 16'h0000, 0);
      total++; if (fetch_addr !== 15'h7FFF) begin bad++; $display("FAIL wrap_fetch got=%h exp=7fff", fetch_addr); end
      total++; if (pc !== 15'h0000 || a_reg !== 16'h1234) begin bad++; $display("FAIL wrap_pc got pc=%h a=%h exp 0000/1234", pc, a_reg); end
   endtask

   task automatic test_reset_mid_write();
      bit seen;
      seen = 1'b0;
      dmem_ready = 1'b0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         #1;
         if (dmem_wr === 1'b1) seen = 1'b1;
         else begin
            imem_valid = imem_req; imem_data = 16'hE308;
            @(negedge clk);
            imem_valid = 1'b0;
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL midwr_reach got=0 exp=1"); end
      reset = 1'b1;
      #1;
      total++; if (dmem_wr !== 1'b0 || dmem_rd !== 1'b0 || retire !== 1'b0) begin bad++; $display("FAIL midwr_drop got wr=%b rd=%b ret=%b exp 0/0/0", dmem_wr, dmem_rd, retire); end
      total++; if (pc !== 15'h0000 || a_reg !== 16'h0000 || d_reg !== 16'h0000) begin bad++; $display("FAIL midwr_regs got pc=%h a=%h d=%h exp 0/0/0", pc, a_reg, d_reg); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_instr(16'h0003, 0, 16'h0000, 0);
      total++; if (fetch_addr !== 15'h0000 || pc !== 15'h0001 || a_reg !== 16'h0003) begin bad++; $display("FAIL midwr_refetch got addr=%h pc=%h a=%h exp 0000/0001/0003", fetch_addr, pc, a_reg); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_a_instr();
      test_c_alu();
      test_mem_write();
      test_mem_rmw();
      test_jump();
      test_pc_wrap();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hack_cpu_core
